// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Bundle of write-back request and register-file write signals
//               shared by the write-back sources and wb_port_arbiter.
//               Ports (per modport):
//                 req_valid / req_ready : per-channel valid/ready handshake
//                 req_data / req_reg    : packed per-channel write data / dest
//                 wb_en / wb_data / wb_reg / wb_ch : registered write port
//                 busy                  : any holding slot occupied
//               modport slave  : arbiter side
//               modport master : source / register-file side
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
);
  localparam int PTR_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH*REG_W-1:0]  req_reg;
  logic                     wb_en;
  logic [DATA_W-1:0]        wb_data;
  logic [REG_W-1:0]         wb_reg;
  logic [PTR_W-1:0]         wb_ch;
  logic                     busy;

  modport slave (
    input  req_valid, req_data, req_reg,
    output req_ready, wb_en, wb_data, wb_reg, wb_ch, busy
  );

  modport master (
    output req_valid, req_data, req_reg,
    input  req_ready, wb_en, wb_data, wb_reg, wb_ch, busy
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : NUM_CH-channel register-file write-back arbiter. Each source
//               pushes {data, dest reg} into a one-entry holding slot; one
//               full slot per cycle is granted and driven onto a registered
//               single write port.
//               Ports:
//                 clk   : rising-edge clock
//                 rst_n : asynchronous active-low reset
//                 bus   : wb_port_arbiter_if.slave (request handshake,
//                         registered write port, busy)
//               Build option:
//                 WBARB_FIXED_PRIO_EN : fixed priority (channel 0 highest)
//                                       instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int REG_W  = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  wb_port_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_CH);

  // Holding slots
  logic [NUM_CH-1:0] r_slotFull;
  logic [DATA_W-1:0] r_slotData [NUM_CH];
  logic [REG_W-1:0]  r_slotReg  [NUM_CH];

  // Arbitration
  logic              w_grantValid;
  logic [PTR_W-1:0]  w_grantIdx;
  logic [NUM_CH-1:0] w_grant;
  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_accept;

  // Registered write port
  logic              r_wbEn;
  logic [DATA_W-1:0] r_wbData;
  logic [REG_W-1:0]  r_wbReg;
  logic [PTR_W-1:0]  r_wbCh;

`ifndef WBARB_FIXED_PRIO_EN
  localparam logic [PTR_W-1:0] c_lastCh = PTR_W'(NUM_CH - 1);
  logic [PTR_W-1:0] r_rrPtr;
`endif

  // Only slots that were already full at the start of the cycle compete, so
  // a same-cycle arrival is never eligible. The round-robin search is split
  // into two ascending passes: channels at or above the pointer first, then
  // a wrap-around pass from channel 0 that only fires if the first found
  // nothing.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
`ifndef WBARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_grantValid && r_slotFull[i] && (PTR_W'(i) >= r_rrPtr)) begin
        w_grantValid = 1'b1;
        w_grantIdx   = PTR_W'(i);
      end
    end
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_grantValid && r_slotFull[i]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_grant[i] = w_grantValid && (w_grantIdx == PTR_W'(i));
    end
  end

  // A granted slot drains this edge, so it can take a new entry on the same
  // edge; ready depends only on state, never on req_valid.
  assign w_ready       = ~r_slotFull | w_grant;
  assign w_accept      = bus.req_valid & w_ready;
  assign bus.req_ready = w_ready;
  assign bus.busy      = |r_slotFull;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slotFull <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_slotData[i] <= '0;
        r_slotReg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_accept[i]) begin
          // Load wins over drain: a grant plus reload keeps the slot full.
          r_slotFull[i] <= 1'b1;
          r_slotData[i] <= bus.req_data[i*DATA_W +: DATA_W];
          r_slotReg[i]  <= bus.req_reg[i*REG_W +: REG_W];
        end else if (w_grant[i]) begin
          r_slotFull[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wbEn   <= 1'b0;
      r_wbData <= '0;
      r_wbReg  <= '0;
      r_wbCh   <= '0;
    end else begin
      r_wbEn <= w_grantValid;
      if (w_grantValid) begin
        r_wbData <= r_slotData[w_grantIdx];
        r_wbReg  <= r_slotReg[w_grantIdx];
        r_wbCh   <= w_grantIdx;
      end
    end
  end

`ifndef WBARB_FIXED_PRIO_EN
  // Pointer moves to the channel just after the winner; it holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_grantValid) begin
      r_rrPtr <= (w_grantIdx == c_lastCh) ? '0 : w_grantIdx + 1'b1;
    end
  end
`endif

  assign bus.wb_en   = r_wbEn;
  assign bus.wb_data = r_wbData;
  assign bus.wb_reg  = r_wbReg;
  assign bus.wb_ch   = r_wbCh;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter. Directed scenarios
//               plus randomized traffic, compared every cycle against a
//               slot-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  wb_port_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cycNum  = 0;

  // Behavioural model: one holding slot per channel plus the write port.
  bit          mFull [NUM_CH];
  logic [15:0] mData [NUM_CH];
  logic [3:0]  mReg  [NUM_CH];
  int          mPtr;
  bit          mEn;
  logic [15:0] mWbData;
  logic [3:0]  mWbReg;
  int          mWbCh;

  // Log of observed write pulses, used by directed scenarios.
  int logCh[$];
  int logData[$];
  int logCyc[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycNum);
    end
  endtask

  // Next winner: first full slot walking upward from the pointer with wrap.
  function automatic int pickChannel();
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (mPtr + k) % NUM_CH;
      if (mFull[c]) return c;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mFull[i] = 1'b0;
      mData[i] = '0;
      mReg[i]  = '0;
    end
    mPtr = 0; mEn = 1'b0; mWbData = '0; mWbReg = '0; mWbCh = 0;
  endfunction

  task automatic setReq(input int ch, input bit v, input logic [15:0] d, input logic [3:0] r);
    bus.req_valid[ch]            = v;
    bus.req_data[ch*DATA_W +: 16] = d;
    bus.req_reg[ch*REG_W +: 4]    = r;
  endtask

  task automatic clearReq();
    bus.req_valid = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at
  // the edge, check the registered port just after.
  task automatic cycle();
    int g;
    bit anyFull;
    logic [NUM_CH-1:0]        v;
    logic [NUM_CH*DATA_W-1:0] d;
    logic [NUM_CH*REG_W-1:0]  r;
    @(negedge clk);
    g = pickChannel();
    anyFull = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      checkVal($sformatf("req_ready[%0d]", i), 32'(bus.req_ready[i]), 32'(!mFull[i] || (g == i)));
      anyFull |= mFull[i];
    end
    checkVal("busy", 32'(bus.busy), 32'(anyFull));
    v = bus.req_valid; d = bus.req_data; r = bus.req_reg;
    @(posedge clk);
    if (g >= 0) begin
      mEn = 1'b1; mWbData = mData[g]; mWbReg = mReg[g]; mWbCh = g;
`ifndef WBARB_FIXED_PRIO_EN
      mPtr = (g + 1) % NUM_CH;
`endif
    end else begin
      mEn = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (v[i] && (!mFull[i] || g == i)) begin
        mFull[i] = 1'b1;
        mData[i] = d[i*DATA_W +: 16];
        mReg[i]  = r[i*REG_W +: 4];
      end else if (g == i) begin
        mFull[i] = 1'b0;
      end
    end
    #1;
    checkVal("wb_en",   32'(bus.wb_en),   32'(mEn));
    checkVal("wb_data", 32'(bus.wb_data), 32'(mWbData));
    checkVal("wb_reg",  32'(bus.wb_reg),  32'(mWbReg));
    checkVal("wb_ch",   32'(bus.wb_ch),   32'(mWbCh));
    if (bus.wb_en) begin
      logCh.push_back(int'(bus.wb_ch));
      logData.push_back(int'(bus.wb_data));
      logCyc.push_back(cycNum);
    end
    cycNum++;
  endtask

  // Asserts reset mid-cycle and verifies outputs clear without a clock edge.
  task automatic applyReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("rst_wb_en",   32'(bus.wb_en),   32'd0);
    checkVal("rst_busy",    32'(bus.busy),    32'd0);
    checkVal("rst_wb_data", 32'(bus.wb_data), 32'd0);
    checkVal("rst_wb_reg",  32'(bus.wb_reg),  32'd0);
    checkVal("rst_wb_ch",   32'(bus.wb_ch),   32'd0);
    checkVal("rst_ready",   32'(bus.req_ready), 32'hF);
    clearReq();
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    logCh.delete(); logData.delete(); logCyc.delete();
  endtask

  initial begin
    int acceptCyc;
    int expStream[4];
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_reg   = '0;
    modelReset();
    applyReset();

    // Single request on ch2
    setReq(2, 1'b1, 16'hBEEF, 4'h5);
    checkVal("t1_ready", 32'(bus.req_ready[2]), 32'd1);
    acceptCyc = cycNum;
    cycle();
    clearReq();
    repeat (3) cycle();
    checkVal("t1_count", 32'(logCh.size()), 32'd1);
    if (logCh.size() == 1) begin
      checkVal("t1_ch",   32'(logCh[0]),   32'd2);
      checkVal("t1_data", 32'(logData[0]), 32'hBEEF);
      checkVal("t1_lat",  32'(logCyc[0]),  32'(acceptCyc + 1));
    end
    checkVal("t1_hold", 32'(bus.wb_data), 32'hBEEF);

    // All four channels at once
    applyReset();
    for (int i = 0; i < NUM_CH; i++) setReq(i, 1'b1, 16'(i), 4'(i + 1));
    cycle();
    clearReq();
    repeat (6) cycle();
    checkVal("t2_count", 32'(logCh.size()), 32'd4);
    for (int i = 0; i < logCh.size() && i < 4; i++) begin
      checkVal($sformatf("t2_ch%0d", i),   32'(logCh[i]),   32'(i));
      checkVal($sformatf("t2_data%0d", i), 32'(logData[i]), 32'(i));
      checkVal($sformatf("t2_cyc%0d", i),  32'(logCyc[i]),  32'(logCyc[0] + i));
    end
    checkVal("t2_busy", 32'(bus.busy), 32'd0);

    // ch0 and ch3 streaming
    applyReset();
    for (int n = 0; n < 8; n++) begin
      setReq(0, 1'b1, 16'h0A00 + 16'(n), 4'h1);
      setReq(3, 1'b1, 16'h0D00 + 16'(n), 4'h2);
      cycle();
    end
`ifdef WBARB_FIXED_PRIO_EN
    expStream = '{0, 0, 0, 0};
    checkVal("t3_busy", 32'(bus.busy), 32'd1);
`else
    expStream = '{0, 3, 0, 3};
`endif
    for (int i = 0; i < 4 && i < logCh.size(); i++)
      checkVal($sformatf("t3_ch%0d", i), 32'(logCh[i]), 32'(expStream[i]));
    clearReq();
    repeat (4) cycle();

    // Back-to-back on ch1
    applyReset();
    for (int n = 1; n <= 5; n++) begin
      setReq(1, 1'b1, 16'(n), 4'h3);
      cycle();
    end
    clearReq();
    repeat (3) cycle();
    checkVal("t4_count", 32'(logCh.size()), 32'd5);
    for (int i = 0; i < 5 && i < logCh.size(); i++) begin
      checkVal($sformatf("t4_data%0d", i), 32'(logData[i]), 32'(i + 1));
      checkVal($sformatf("t4_cyc%0d", i),  32'(logCyc[i]),  32'(logCyc[0] + i));
    end

    // Same destination register from ch1 and ch2
    applyReset();
    setReq(1, 1'b1, 16'h1111, 4'h7);
    setReq(2, 1'b1, 16'h2222, 4'h7);
    cycle();
    clearReq();
    repeat (3) cycle();
    checkVal("t5_count", 32'(logCh.size()), 32'd2);
    if (logCh.size() == 2) begin
      checkVal("t5_first",  32'(logData[0]), 32'h1111);
      checkVal("t5_second", 32'(logData[1]), 32'h2222);
    end
    checkVal("t5_reg", 32'(bus.wb_reg), 32'h7);

    // Asynchronous reset with three slots full
    applyReset();
    for (int i = 0; i < NUM_CH; i++) setReq(i, 1'b1, 16'h5000 + 16'(i), 4'(i));
    cycle();
    clearReq();
    cycle();
    checkVal("t6_busy_pre", 32'(bus.busy), 32'd1);
    applyReset();
    setReq(1, 1'b1, 16'h00B1, 4'h9);
    setReq(0, 1'b1, 16'h00A0, 4'h8);
    cycle();
    clearReq();
    repeat (3) cycle();
    checkVal("t6_count", 32'(logCh.size()), 32'd2);
    if (logCh.size() == 2) begin
      checkVal("t6_first",  32'(logCh[0]), 32'd0);
      checkVal("t6_second", 32'(logCh[1]), 32'd1);
    end

    // Randomized traffic at several densities
    applyReset();
    for (int phase = 0; phase < 3; phase++) begin
      int density;
      density = (phase == 0) ? 30 : (phase == 1) ? 70 : 100;
      for (int n = 0; n < 200; n++) begin
        for (int i = 0; i < NUM_CH; i++)
          setReq(i, $urandom_range(0, 99) < density, 16'($urandom), 4'($urandom));
        cycle();
      end
    end
    clearReq();
    repeat (6) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Parametrised N-channel register-file write-back arbiter; successor to the fixed 2-way, unregistered write-back port select.
- Sits between execution/memory write-back sources and the register-file write port.
- Each source pushes {data, dest reg} over valid/ready into a one-entry holding slot.
- Arbiter grants one slot per cycle, round-robin, and drives a registered single write port.

Parameters:
NUM_CH, 4, number of write-back source channels (>=2)
DATA_W, 16, write data width
REG_W, 4, destination register index width
PTR_W, $clog2(NUM_CH), round-robin pointer width (derived; do not override)

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_CH  per-channel write request valid
req_ready  output  NUM_CH  per-channel accept; transfer when valid&ready at edge
req_data  input  NUM_CH*DATA_W  packed write data; channel i at [i*DATA_W +: DATA_W]
req_reg  input  NUM_CH*REG_W  packed dest register; channel i at [i*REG_W +: REG_W]
wb_en  output  1  register-file write enable, registered
wb_data  output  DATA_W  write data, registered
wb_reg  output  REG_W  destination register, registered
wb_ch  output  PTR_W  channel that produced the current wb_en pulse
busy  output  1  OR of all slot-full flags (combinational)

Behaviour:
- Per channel: slot_full[i], slot_data[i], slot_reg[i].
- req_ready[i] = ~slot_full[i] | grant[i]. Combinational from state only, never from req_valid.
- Accept (valid&ready) at edge k loads the slot and sets slot_full.
- Grant and load on the same edge: slot reloads and stays full; no bubble.
- Grant and no load: slot_full clears.
- Arbitration is combinational over slot_full only. Same-cycle arrivals are not eligible.
- Search order starts at rr_ptr and wraps: rr_ptr, rr_ptr+1, …, NUM_CH-1, 0, …
- At most one grant per cycle.
- After a grant to channel g: rr_ptr <= (g==NUM_CH-1) ? 0 : g+1.
- No grant: rr_ptr holds.
- Output register on a grant: wb_en<=1, wb_data<=slot_data[g], wb_reg<=slot_reg[g], wb_ch<=g.
- No grant: wb_en<=0; wb_data/wb_reg/wb_ch hold their last values.
- Latency: accept at edge k -> wb_en high in cycle after edge k+1 at best (2 edges).
- Worst-case wait with all channels full is NUM_CH grants.
- Throughput: one write per cycle when any slot is full.
- A channel with a continuous stream is served once per NUM_CH cycles under full contention, and every cycle when it is alone.
- No merging or reordering. Two channels targeting the same register are written in grant order; the later grant wins.
- busy = |slot_full.
- Reset (async assert, any time, including mid-transfer):
  - slot_full=0, rr_ptr=0
  - wb_en=0, wb_data=0, wb_reg=0, wb_ch=0
  - pending slot contents are discarded.
- Deassertion is synchronous to clk by the upstream reset synchroniser.
- req_valid deasserted while the slot is full has no effect; the slot content is already committed.

Optional Feature:
- Macro: WBARB_FIXED_PRIO_EN.
- Defined:
  - Round-robin replaced by fixed priority; channel 0 highest, NUM_CH-1 lowest.
  - rr_ptr logic removed; search always starts at 0.
  - Lower channels can starve higher-index ones; intended for the configuration where channel 0 is the load path.
- Undefined (default): round-robin as above.
- All other behaviour (slots, latency, reset) identical in both builds.

Test Plan:
- Reset then single request: ch2 valid, data=16'hBEEF, reg=4'h5, one cycle.
  -> req_ready[2]=1 at accept; wb_en=1 with wb_data=BEEF, wb_reg=5, wb_ch=2 exactly 2 edges after accept; then wb_en=0 and data holds.
- All 4 channels request in the same cycle (data 16'h0000..0003, reg 1..4), rr_ptr=0.
  -> wb_ch sequence 0,1,2,3 on consecutive cycles; busy drops after the 4th grant.
  -> with WBARB_FIXED_PRIO_EN the order is also 0,1,2,3.
- Ch0 and ch3 stream continuously for 8 cycles.
  -> grants alternate 0,3,0,3; req_ready of each never low two cycles in a row.
  -> fixed-priority build: ch0 every cycle, ch3 starved, busy stays 1.
- Back-to-back on one channel: ch1 valid 5 cycles, data 1..5.
  -> wb_en high 5 consecutive cycles, data 1..5 in order, no bubble after the first.
- Two channels write reg 4'h7, ch1=16'h1111 then ch2=16'h2222, same cycle, rr_ptr=0.
  -> two wb_en pulses in order 1111 then 2222.
- rst_n asserted asynchronously mid-cycle with 3 slots full.
  -> wb_en, busy, slots, wb_* go to 0 immediately without waiting for a clock edge; after release, first new request gets ch-order from rr_ptr=0.
